game_state_controller: RTL

// Consumer end of the goomba mover's lose line. It owns the round flow: lives, hit

---
 rtl/game_pkg.sv | 12 +
 rtl/frame_tick_gen.sv | 23 ++
 rtl/game_state_controller.sv | 113 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types for the round controller and the sprite movers.
// Tile codes live here so the movers and the renderer agree on the map encoding.
package game_pkg;

  typedef enum logic [2:0] {PLAY, HIT, RESPAWN, GAME_OVER, WIN} game_state_t;

  localparam logic [1:0] BDR = 2'd0;
  localparam logic [1:0] SKY = 2'd1;
  localparam logic [1:0] BLK = 2'd2;
  localparam logic [1:0] GND = 2'd3;

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame counter; tick is high on the last cycle of each frame.
// Only reset restarts it, so frame timing never drifts with game state.
module frame_tick_gen #(
  parameter int FRAME_CYCLES = 420000
) (
  input  logic vga_clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge vga_clock) begin
    if (reset)     count <= '0;
    else if (tick) count <= '0;
    else           count <= count + CW'(1);
  end

  assign tick = (count == CW'(FRAME_CYCLES - 1));

endmodule

// File: rtl/game_state_controller.sv
// Round flow controller: lives, hit freeze/blink, respawn, game-over, win and restart.
// Drives freeze/mover_reset back into the movers and status flags to the renderer.
module game_state_controller
  import game_pkg::*;
#(
  parameter int START_LIVES  = 3,
  parameter int FRAME_CYCLES = 420000,
  parameter int HIT_FRAMES   = 60,
  parameter int BLINK_FRAMES = 6,
  parameter int GRACE_FRAMES = 90,
  parameter int GOAL_X       = 600
) (
  input  logic               vga_clock,
  input  logic               reset,
  input  logic               lose,
  input  logic signed [31:0] mario_x,
  input  logic               start,
  output logic               freeze,
  output logic               mover_reset,
  output logic [1:0]         lives,
  output logic               mario_visible,
  output logic               game_over,
  output logic               win
);

  game_state_t state, state_d;
  logic        tick;
  logic [7:0]  grace, hit_cnt, blink_cnt;
  logic        start_q;
  logic        start_edge, hit_now, goal_reached, hit_done, blink_wrap;
  logic        freeze_d, mover_reset_d, visible_d, game_over_d, win_d;

  frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_tick (
    .vga_clock (vga_clock),
    .reset     (reset),
    .tick      (tick)
  );

  // Hit and blink counters both count frame ticks since entering HIT.
  assign start_edge   = start && !start_q;
  assign hit_now      = lose && (grace == 8'd0);
  assign goal_reached = (mario_x >= GOAL_X);
  assign hit_done     = tick && (hit_cnt == 8'(HIT_FRAMES - 1));
  assign blink_wrap   = tick && (blink_cnt == 8'(BLINK_FRAMES - 1));

  always_comb begin
    state_d = state;
    unique case (state)
      PLAY: begin
        if (hit_now)           state_d = HIT;
        else if (goal_reached) state_d = WIN;
      end
      HIT: begin
        if (hit_done) state_d = (lives == 2'd0) ? GAME_OVER : RESPAWN;
      end
      RESPAWN:        state_d = PLAY;
      GAME_OVER, WIN: if (start_edge) state_d = RESPAWN;
      default:        state_d = PLAY;
    endcase
  end

  // Outputs are decoded from the current state and registered, so they trail the state by one cycle.
  always_comb begin
    freeze_d      = (state != PLAY);
    mover_reset_d = (state == RESPAWN);
    game_over_d   = (state == GAME_OVER);
    win_d         = (state == WIN);
    visible_d     = (state == HIT) ? (mario_visible ^ blink_wrap) : 1'b1;
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state         <= PLAY;
      lives         <= 2'(START_LIVES);
      grace         <= 8'd0;
      hit_cnt       <= 8'd0;
      blink_cnt     <= 8'd0;
      start_q       <= 1'b0;
      freeze        <= 1'b0;
      mover_reset   <= 1'b0;
      mario_visible <= 1'b1;
      game_over     <= 1'b0;
      win           <= 1'b0;
    end else begin
      state         <= state_d;
      start_q       <= start;
      freeze        <= freeze_d;
      mover_reset   <= mover_reset_d;
      mario_visible <= visible_d;
      game_over     <= game_over_d;
      win           <= win_d;

      if (state == PLAY) begin
        if (tick && grace != 8'd0) grace <= grace - 8'd1;
        if (hit_now) begin
          lives     <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
          hit_cnt   <= 8'd0;
          blink_cnt <= 8'd0;
        end
      end

      if (state == HIT && tick) begin
        hit_cnt   <= hit_cnt + 8'd1;
        blink_cnt <= blink_wrap ? 8'd0 : blink_cnt + 8'd1;
      end

      if (state == RESPAWN) grace <= 8'(GRACE_FRAMES);

      if ((state == GAME_OVER || state == WIN) && start_edge) lives <= 2'(START_LIVES);
    end
  end

endmodule
